// File: rtl/ram_1p_host_arb_if.sv
// Host-side (Ibex instruction/data) and RAM-side signals of the two-host
// single-port RAM front end; the arbiter takes the slave view.
interface ram_1p_host_arb_if #(
    parameter int Depth = 128
);
    localparam int RamAw = $clog2(Depth);

    logic             instr_req_i;
    logic [31:0]      instr_addr_i;
    logic             instr_gnt_o;
    logic             instr_rvalid_o;
    logic [31:0]      instr_rdata_o;
    logic             instr_err_o;

    logic             data_req_i;
    logic             data_we_i;
    logic [3:0]       data_be_i;
    logic [31:0]      data_addr_i;
    logic [31:0]      data_wdata_i;
    logic             data_gnt_o;
    logic             data_rvalid_o;
    logic [31:0]      data_rdata_o;
    logic             data_err_o;

    logic             ram_req_o;
    logic             ram_write_o;
    logic [RamAw-1:0] ram_addr_o;
    logic [31:0]      ram_wdata_o;
    logic             ram_rvalid_i;
    logic [31:0]      ram_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o,
        input  ram_rvalid_i, ram_rdata_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o,
        output ram_rvalid_i, ram_rdata_i
    );
endinterface

// File: rtl/ram_1p_host_arb.sv
// Arbitrates Ibex instr/data hosts onto one single-port RAM, data first, and
// turns byte-enable writes into a read-modify-write pair of RAM accesses.
module ram_1p_host_arb #(
    parameter int          Depth   = 128,
    parameter logic [31:0] RamBase = 32'h0000_0000
) (
    input logic              clk_i,
    input logic              rst_ni,
    ram_1p_host_arb_if.slave bus
);
    localparam int RamAw = $clog2(Depth);

    typedef enum logic {IDLE, RMW_WR} state_e;
    typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;

    // One outstanding response; no_ram entries complete without the RAM.
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
        logic   internal;
        logic   no_ram;
    } rsp_t;

    state_e           state_q;
    rsp_t             rsp_q, rsp_d;
    logic [RamAw-1:0] rmw_addr_q;
    logic [3:0]       rmw_be_q;
    logic [31:0]      rmw_wdata_q;

    logic             data_hit, instr_hit;
    logic             data_none, data_partial;
    logic             data_sel, instr_sel;
    logic [31:0]      merged;
    logic             rsp_fire, rsp_zero;

    function automatic logic in_window(input logic [31:0] addr);
        return addr[31:RamAw+2] == RamBase[31:RamAw+2];
    endfunction

    always_comb begin
        data_hit     = in_window(bus.data_addr_i);
        instr_hit    = in_window(bus.instr_addr_i);
        data_none    = bus.data_we_i && (bus.data_be_i == 4'b0000);
        data_partial = bus.data_we_i && !data_none && (bus.data_be_i != 4'b1111);
        data_sel     = rst_ni && (state_q == IDLE) && bus.data_req_i;
        instr_sel    = rst_ni && (state_q == IDLE) && bus.instr_req_i && !bus.data_req_i;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = rmw_be_q[i] ? rmw_wdata_q[8*i +: 8] : bus.ram_rdata_i[8*i +: 8];
        end
    end

    assign bus.data_gnt_o  = data_sel;
    assign bus.instr_gnt_o = instr_sel;

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path infers a latch.
        bus.ram_req_o   = 1'b0;
        bus.ram_write_o = 1'b0;
        bus.ram_addr_o  = bus.data_addr_i[RamAw+1:2];
        bus.ram_wdata_o = bus.data_wdata_i;
        rsp_d           = '0;
        if (rst_ni && state_q == RMW_WR) begin
            bus.ram_req_o   = 1'b1;
            bus.ram_write_o = 1'b1;
            bus.ram_addr_o  = rmw_addr_q;
            bus.ram_wdata_o = merged;
            rsp_d.valid     = 1'b1;
            rsp_d.owner     = OWN_DATA;
        end else if (data_sel) begin
            rsp_d.valid = 1'b1;
            rsp_d.owner = OWN_DATA;
            if (!data_hit) begin
                rsp_d.err    = 1'b1;
                rsp_d.no_ram = 1'b1;
            end else if (data_none) begin
                rsp_d.no_ram = 1'b1;
            end else begin
                // A partial write starts as a plain read whose data feeds the merge.
                bus.ram_req_o   = 1'b1;
                bus.ram_write_o = bus.data_we_i && !data_partial;
                rsp_d.internal  = data_partial;
            end
        end else if (instr_sel) begin
            bus.ram_addr_o = bus.instr_addr_i[RamAw+1:2];
            rsp_d.valid    = 1'b1;
            rsp_d.owner    = OWN_INSTR;
            if (!instr_hit) begin
                rsp_d.err    = 1'b1;
                rsp_d.no_ram = 1'b1;
            end else begin
                bus.ram_req_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rsp_q       <= '0;
            rmw_addr_q  <= '0;
            rmw_be_q    <= '0;
            rmw_wdata_q <= '0;
        end else begin
            // NOTE: non-blocking for all state so every register samples pre-edge values.
            rsp_q <= rsp_d;
            case (state_q)
                IDLE: begin
                    if (data_sel && data_hit && data_partial) begin
                        state_q     <= RMW_WR;
                        rmw_addr_q  <= bus.data_addr_i[RamAw+1:2];
                        rmw_be_q    <= bus.data_be_i;
                        rmw_wdata_q <= bus.data_wdata_i;
                    end
                end
                RMW_WR:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_fire = rsp_q.valid && !rsp_q.internal && (rsp_q.no_ram || bus.ram_rvalid_i);
    assign rsp_zero = rsp_q.valid && rsp_q.err;

    assign bus.data_rvalid_o  = rsp_fire && (rsp_q.owner == OWN_DATA);
    assign bus.data_err_o     = rsp_fire && (rsp_q.owner == OWN_DATA) && rsp_q.err;
    assign bus.data_rdata_o   = (rsp_zero && rsp_q.owner == OWN_DATA) ? 32'h0 : bus.ram_rdata_i;
    assign bus.instr_rvalid_o = rsp_fire && (rsp_q.owner == OWN_INSTR);
    assign bus.instr_err_o    = rsp_fire && (rsp_q.owner == OWN_INSTR) && rsp_q.err;
    assign bus.instr_rdata_o  = (rsp_zero && rsp_q.owner == OWN_INSTR) ? 32'h0 : bus.ram_rdata_i;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.instr_addr_i[1:0], bus.data_addr_i[1:0]};
endmodule

// File: doc/ram_1p_host_arb.md
# ram_1p_host_arb

Two-host front end for the single-port on-chip RAM in the DE10-Lite system. Accepts Ibex instruction-fetch and data requests (req/gnt/rvalid protocol), arbitrates them onto one RAM port, and emulates byte-enable writes with a read-modify-write (RMW), since the RAM has only a whole-word write strobe. Addresses outside the RAM window get a one-cycle error response.

## Interface

- Depth, 128: RAM depth in 32-bit words.
- RamBase, 32'h0000_0000: byte base address of the RAM window, aligned to Depth*4.
- RamAw, $clog2(Depth): RAM word-address width (derived).

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant, combinational
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch error, qualified by instr_rvalid_o
- data_req_i  in  1  data request
- data_we_i  in  1  write when 1
- data_be_i  in  4  byte enables (writes only)
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  data grant, combinational
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  read data
- data_err_o  out  1  data error, qualified by data_rvalid_o
- ram_req_o  out  1  RAM access strobe
- ram_write_o  out  1  RAM write
- ram_addr_o  out  RamAw  RAM word address
- ram_wdata_o  out  32  RAM write data
- ram_rvalid_i  in  1  RAM response, one cycle after ram_req_o
- ram_rdata_i  in  32  RAM read data

## Operation

- States: IDLE, RMW_WR. Reset state IDLE.
- IDLE arbitration: fixed priority, data over instr. The loser's gnt stays 0, and the host holds req until granted.
- Address decode: in range iff addr[31:2] is within [RamBase, RamBase+Depth*4). ram_addr_o = addr[RamAw+1:2]. addr[1:0] is ignored.
- Out-of-range request: granted, and no RAM access is made. Next cycle, rvalid=1, err=1, rdata=0.
- Read, or write with be=4'b1111: granted. ram_req_o=1, ram_write_o=data_we_i, ram_wdata_o=data_wdata_i. State stays IDLE.
- Write with be=4'b0000: granted, and no RAM access is made. Next cycle, rvalid=1, err=0.
- Partial write (be is not 0000 or 1111): granted.
  - Issue a RAM read and latch addr, be and wdata. Go to RMW_WR.
  - In RMW_WR, merge per byte: byte i = be[i] ? wdata[i] : ram_rdata_i[i]. Issue the RAM write and return to IDLE.
  - Both gnt outputs are 0 in RMW_WR.
- Response routing: a 1-entry response register holds {valid, owner, err, internal}.
  - The RMW read response is internal. It is consumed by the merge and never raises rvalid.
  - Otherwise ram_rvalid_i drives the owner's rvalid, and rdata is passed through from ram_rdata_i.
- The non-owner's rvalid is 0. Its rdata is don't-care and is driven with ram_rdata_i.

## Timing

- Reset values: all gnt, rvalid, err and ram_req_o are 0; ram_write_o is 0; the response register is cleared; state is IDLE.
- gnt is 0 whenever rst_ni is 0.
- Read, full-word write, error and be=0 accesses: gnt at cycle T, rvalid at T+1. Back-to-back grants are allowed every cycle.
- Partial write: gnt and RAM read at T, merged RAM write at T+1, data_rvalid_o at T+2. No grant to either host at T+1. A new grant is possible at T+2.
- Simultaneous instr and data requests at T: data_gnt_o=1 and instr_gnt_o=0. Instr is granted at T+1, provided no data request is pending and the data access is not a partial write.
- Reset asserted mid-RMW: the write is abandoned and the RAM is untouched. No rvalid is issued, and the block is in IDLE when rst_ni deasserts.
- There is at most one outstanding response per cycle. rvalid is never asserted to both hosts in the same cycle.

## Test plan

- Preload word 5 = 32'h1122_3344. Fetch from RamBase+0x14 -> instr_gnt_o=1 at T; instr_rvalid_o=1 at T+1 with rdata=32'h1122_3344 and err=0.
- Write word 5 with be=4'b0101 and wdata=32'hAABB_CCDD -> RAM write at T+1 of 32'h11BB_33DD; data_rvalid_o at T+2; a subsequent read returns 32'h11BB_33DD.
- instr_req_i and data_req_i both high at T (data is a read) -> data granted at T and instr at T+1. The two rvalids come in consecutive cycles, each routed to its own host.
- Partial write at T with instr_req_i held high -> instr_gnt_o=0 at T and T+1, then 1 at T+2.
- Data read at RamBase+Depth*4 -> granted, ram_req_o=0; data_rvalid_o=1, data_err_o=1 and rdata=0 at T+1.
- Assert rst_ni=0 during RMW_WR -> ram_req_o=0 immediately. Memory is unchanged, and no rvalid is issued after reset.
